// File: rtl/ahb_adc_scan_sequencer.sv
// AHB-Lite slave that scans masked ADC channels in the background and keeps the
// latest result plus new/overrun flags per channel, readable with zero wait states.
module ahb_adc_scan_sequencer #(
  parameter int N_CH    = 16,
  parameter int RES_W   = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic             Read,
  output logic [3:0]       Channel_Select,
  input  logic [RES_W-1:0] Result,
  input  logic             RDY_BSYn,
  output logic             irq
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_CONVERT, ST_NEXT} state_t;

  state_t           state;
  logic [3:0]       cur;
  logic [TW-1:0]    tcnt;
  logic             scan_en, irq_en, oneshot_pend, to_err, scan_done;
  logic [3:0]       last_ch;
  logic [N_CH-1:0]  mask, new_f, ovr_f;
  logic [RES_W-1:0] data_res [N_CH];
  logic             dp_valid, dp_write;
  logic [5:0]       dp_idx;
  logic [3:0]       dp_ch;
  logic             dp_is_data;
  logic             first_ok, next_ok;
  logic [3:0]       first_ch, next_ch;
  logic             unused_ok;

  assign unused_ok  = ^{HSIZE, HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA};
  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign irq        = irq_en & (to_err | scan_done);
  assign dp_ch      = dp_idx[3:0];
  assign dp_is_data = (dp_idx[5:4] == 2'b01) && ({1'b0, dp_ch} < 5'(N_CH));

  // Lowest enabled channel overall, and lowest enabled channel above cur.
  always_comb begin
    first_ok = 1'b0;
    first_ch = '0;
    next_ok  = 1'b0;
    next_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_ok = 1'b1;
        first_ch = 4'(i);
      end
      if (mask[i] && (i > int'(cur))) begin
        next_ok = 1'b1;
        next_ch = 4'(i);
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_idx)
        6'd0: HRDATA[2:0] = {irq_en, 1'b0, scan_en};
        6'd1: HRDATA[N_CH-1:0] = mask;
        6'd2: begin
          HRDATA[0]     = (state != ST_IDLE);
          HRDATA[1]     = to_err;
          HRDATA[2]     = scan_done;
          HRDATA[19:16] = last_ch;
        end
        default: begin
          if (dp_is_data) begin
            HRDATA[31]        = new_f[dp_ch];
            HRDATA[30]        = ovr_f[dp_ch];
            HRDATA[RES_W-1:0] = data_res[dp_ch];
          end
        end
      endcase
    end
  end

  // Bus side effects come first so that FSM events later in this block win
  // over a same-edge W1C or read-clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state          <= ST_IDLE;
      cur            <= '0;
      tcnt           <= '0;
      scan_en        <= 1'b0;
      irq_en         <= 1'b0;
      oneshot_pend   <= 1'b0;
      to_err         <= 1'b0;
      scan_done      <= 1'b0;
      last_ch        <= '0;
      mask           <= '0;
      new_f          <= '0;
      ovr_f          <= '0;
      dp_valid       <= 1'b0;
      dp_write       <= 1'b0;
      dp_idx         <= '0;
      Read           <= 1'b0;
      Channel_Select <= '0;
      for (int i = 0; i < N_CH; i++) data_res[i] <= '0;
    end else begin
      if (HREADY) begin
        dp_valid <= HSEL & HTRANS[1];
        dp_write <= HWRITE;
        dp_idx   <= HADDR[7:2];
      end
      if (dp_valid && dp_write) begin
        case (dp_idx)
          6'd0: begin
            scan_en <= HWDATA[0];
            irq_en  <= HWDATA[2];
            if (HWDATA[1] && (state == ST_IDLE)) oneshot_pend <= 1'b1;
          end
          6'd1: mask <= HWDATA[N_CH-1:0];
          6'd2: begin
            if (HWDATA[1]) to_err    <= 1'b0;
            if (HWDATA[2]) scan_done <= 1'b0;
          end
          default: ;
        endcase
      end
      if (dp_valid && !dp_write && dp_is_data) begin
        new_f[dp_ch] <= 1'b0;
        ovr_f[dp_ch] <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if ((scan_en || oneshot_pend) && first_ok) begin
            cur            <= first_ch;
            Channel_Select <= first_ch;
            Read           <= 1'b0;
            oneshot_pend   <= 1'b0;
            state          <= ST_SELECT;
          end else if (!first_ok) begin
            oneshot_pend <= 1'b0;
          end
        end
        ST_SELECT: begin
          Read  <= 1'b1;
          tcnt  <= '0;
          state <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (RDY_BSYn) begin
            data_res[cur] <= Result;
            new_f[cur]    <= 1'b1;
            if (new_f[cur]) ovr_f[cur] <= 1'b1;
            last_ch <= cur;
            Read    <= 1'b0;
            state   <= ST_NEXT;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            to_err <= 1'b1;
            Read   <= 1'b0;
            state  <= ST_NEXT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (next_ok) begin
            cur            <= next_ch;
            Channel_Select <= next_ch;
            state          <= ST_SELECT;
          end else begin
            scan_done <= 1'b1;
            if (scan_en && first_ok) begin
              cur            <= first_ch;
              Channel_Select <= first_ch;
              state          <= ST_SELECT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_adc_scan_sequencer.sv
// Self-checking bench for ahb_adc_scan_sequencer: directed boundary cases plus
// randomized one-shot passes checked against a per-channel scoreboard.
module tb_ahb_adc_scan_sequencer;
  localparam int N_CH    = 16;
  localparam int RES_W   = 12;
  localparam int TIMEOUT = 8;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_MASK   = 32'h04;
  localparam logic [31:0] A_STATUS = 32'h08;

  logic             HCLK = 1'b0;
  logic             HRESET, HSEL, HWRITE, HREADY;
  logic [31:0]      HADDR, HWDATA, HRDATA;
  logic [2:0]       HSIZE;
  logic [1:0]       HTRANS;
  logic             HREADYOUT, HRESP, Read, RDY_BSYn, irq;
  logic [3:0]       Channel_Select;
  logic [RES_W-1:0] Result;

  int tests_run    = 0;
  int tests_failed = 0;

  // ADC responder controls: 0 = answer after adc_lat cycles, 1 = never answer,
  // 2 = answer only in the cycle where fire_now is set.
  int               adc_mode = 0;
  int               adc_lat  = 3;
  logic             fire_now = 1'b0;
  logic [RES_W-1:0] adc_val [N_CH];
  int               adc_cnt;

  logic [3:0] seq_log [4096];
  int         seq_n   = 0;
  int         read_hi = 0;

  logic [RES_W-1:0] model_val [N_CH];
  logic             model_new [N_CH];
  logic             model_ovr [N_CH];
  logic [3:0]       model_last;

  ahb_adc_scan_sequencer #(.N_CH(N_CH), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .Read(Read),
    .Channel_Select(Channel_Select), .Result(Result), .RDY_BSYn(RDY_BSYn), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    RDY_BSYn = 1'b0;
    Result   = '0;
    adc_cnt  = 0;
    forever begin
      @(negedge HCLK);
      RDY_BSYn = 1'b0;
      if (!Read) begin
        adc_cnt = 0;
      end else if (adc_mode == 0) begin
        adc_cnt++;
        if (adc_cnt >= adc_lat) begin
          RDY_BSYn = 1'b1;
          Result   = adc_val[Channel_Select];
          adc_cnt  = 0;
        end
      end else if (adc_mode == 2 && fire_now) begin
        RDY_BSYn = 1'b1;
        Result   = adc_val[Channel_Select];
      end
    end
  end

  // Logs the channel of every conversion request and counts Read-high cycles.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge HCLK);
      #2;
      if (Read && !prev && seq_n < 4096) begin
        seq_log[seq_n] = Channel_Select;
        seq_n++;
      end
      if (Read) read_hi++;
      prev = Read;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      model_val[c] = '0;
      model_new[c] = 1'b0;
      model_ovr[c] = 1'b0;
    end
    model_last = '0;
  endfunction

  function automatic void model_capture(input int ch, input logic [RES_W-1:0] v);
    model_ovr[ch] = model_ovr[ch] | model_new[ch];
    model_new[ch] = 1'b1;
    model_val[ch] = v;
    model_last    = 4'(ch);
  endfunction

  function automatic logic [31:0] model_expected(input int ch);
    return {model_new[ch], model_ovr[ch], 30'(model_val[ch])};
  endfunction

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    bus_idle();
    data = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(addr, d);
    checkOutput(tag, d, exp);
  endtask

  task automatic check_data(input int ch);
    logic [31:0] d;
    ahb_read(32'h40 + 32'(4 * ch), d);
    checkOutput($sformatf("data%0d", ch), d, model_expected(ch));
    model_new[ch] = 1'b0;
    model_ovr[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      ahb_read(A_STATUS, s);
      n++;
    end while (s[0] && n < 300);
    checkOutput("busy_clear", {31'b0, s[0]}, 32'h0);
  endtask

  task automatic wait_read_high();
    int n;
    n = 0;
    while (!Read && n < 64) begin
      @(posedge HCLK); #1;
      n++;
    end
    checkOutput("read_rise", {31'b0, Read}, 32'h1);
  endtask

  task automatic applyStimulus(input int iter);
    logic [15:0] m;
    logic [31:0] s;
    int st, k;
    m = (iter == 0) ? 16'h0 : 16'($urandom);
    adc_lat = $urandom_range(1, 5);
    for (int c = 0; c < N_CH; c++) adc_val[c] = RES_W'($urandom);
    ahb_write(A_MASK, {16'h0, m});
    st = seq_n;
    ahb_write(A_CTRL, 32'h2);
    wait_idle();
    k = 0;
    for (int c = 0; c < N_CH; c++) begin
      if (m[c]) begin
        checkOutput($sformatf("rnd%0d_seq%0d", iter, k), {28'h0, seq_log[st + k]}, 32'(c));
        model_capture(c, adc_val[c]);
        k++;
      end
    end
    checkOutput($sformatf("rnd%0d_nconv", iter), 32'(seq_n - st), 32'(k));
    ahb_read(A_STATUS, s);
    if (m != 16'h0)
      checkOutput($sformatf("rnd%0d_status", iter), s, 32'h4 | (32'(model_last) << 16));
    else
      checkOutput($sformatf("rnd%0d_status_idle", iter), {29'h0, s[2:0]}, 32'h0);
    ahb_write(A_STATUS, 32'h4);
    repeat (4) check_data($urandom_range(0, N_CH - 1));
  endtask

  initial begin
    logic [31:0] d;
    int st, n, rh;
    HRESET = 1'b1; HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HREADY = 1'b1;
    bus_idle();
    for (int c = 0; c < N_CH; c++) adc_val[c] = '0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1;
    checkOutput("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    checkOutput("rst_hresp", {31'b0, HRESP}, 32'h0);
    checkOutput("rst_read", {31'b0, Read}, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    check_read("rst_ctrl", A_CTRL, 32'h0);
    check_read("rst_mask", A_MASK, 32'h0);
    check_read("rst_status", A_STATUS, 32'h0);
    check_data(0);

    // Write then read of CH_MASK in consecutive cycles.
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_MASK;
    @(posedge HCLK); #1;
    HWDATA = 32'h3; HWRITE = 1'b0; HADDR = A_MASK;
    @(posedge HCLK); #1;
    bus_idle();
    checkOutput("b2b_mask", HRDATA, 32'h3);
    checkOutput("b2b_ready", {31'b0, HREADYOUT}, 32'h1);
    @(posedge HCLK); #1;
    check_read("unmapped_3c", 32'h3C, 32'h0);
    ahb_write(A_MASK, 32'hFFFF_FFFF);
    check_read("mask_upper_bits", A_MASK, 32'h0000_FFFF);

    // One-shot over channels 0 and 2.
    adc_mode = 0; adc_lat = 3;
    adc_val[0] = 12'h123; adc_val[2] = 12'hABC;
    ahb_write(A_MASK, 32'h5);
    st = seq_n;
    ahb_write(A_CTRL, 32'h2);
    wait_idle();
    checkOutput("os_seq0", {28'h0, seq_log[st]}, 32'h0);
    checkOutput("os_seq1", {28'h0, seq_log[st + 1]}, 32'h2);
    checkOutput("os_nconv", 32'(seq_n - st), 32'h2);
    model_capture(0, 12'h123);
    model_capture(2, 12'hABC);
    check_read("os_status", A_STATUS, 32'h0002_0004);
    check_data(0);
    check_data(2);
    check_data(0);
    ahb_write(A_STATUS, 32'h4);
    check_read("os_done_w1c", A_STATUS, 32'h0002_0000);

    // Result capture on the same edge that ends a DATA read of that channel.
    adc_mode = 2; adc_val[0] = 12'h5A5;
    ahb_write(A_MASK, 32'h1);
    ahb_write(A_CTRL, 32'h2);
    wait_read_high();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h40;
    @(posedge HCLK); #1;
    bus_idle();
    fire_now = 1'b1;
    d = HRDATA;
    @(posedge HCLK); #1;
    fire_now = 1'b0;
    checkOutput("same_edge_old", d, model_expected(0));
    model_new[0] = 1'b0;
    model_ovr[0] = 1'b0;
    model_capture(0, 12'h5A5);
    wait_idle();
    adc_mode = 0;
    check_data(0);
    ahb_write(A_STATUS, 32'h4);

    // Continuous scan with wrap, unread results overrun.
    adc_lat = 2;
    adc_val[0] = RES_W'($urandom); adc_val[15] = RES_W'($urandom);
    ahb_write(A_MASK, 32'h8001);
    st = seq_n;
    ahb_write(A_CTRL, 32'h1);
    n = 0;
    while (seq_n < st + 4 && n < 500) begin
      @(posedge HCLK); #1;
      n++;
    end
    ahb_write(A_CTRL, 32'h0);
    wait_idle();
    checkOutput("cont_seq0", {28'h0, seq_log[st]}, 32'd0);
    checkOutput("cont_seq1", {28'h0, seq_log[st + 1]}, 32'd15);
    checkOutput("cont_seq2", {28'h0, seq_log[st + 2]}, 32'd0);
    checkOutput("cont_seq3", {28'h0, seq_log[st + 3]}, 32'd15);
    model_capture(0, adc_val[0]);  model_capture(0, adc_val[0]);
    model_capture(15, adc_val[15]); model_capture(15, adc_val[15]);
    check_data(15);
    check_data(0);
    ahb_write(A_STATUS, 32'h4);

    // Conversion timeout with the interrupt enabled.
    adc_mode = 1;
    ahb_write(A_MASK, 32'h2);
    rh = read_hi;
    ahb_write(A_CTRL, 32'h6);
    wait_idle();
    checkOutput("to_read_cycles", 32'(read_hi - rh), 32'(TIMEOUT));
    ahb_read(A_STATUS, d);
    checkOutput("to_err", {31'b0, d[1]}, 32'h1);
    checkOutput("to_done", {31'b0, d[2]}, 32'h1);
    checkOutput("to_irq", {31'b0, irq}, 32'h1);
    check_data(1);
    ahb_write(A_STATUS, 32'h2);
    ahb_read(A_STATUS, d);
    checkOutput("to_err_w1c", {31'b0, d[1]}, 32'h0);
    checkOutput("irq_on_done", {31'b0, irq}, 32'h1);
    ahb_write(A_STATUS, 32'h4);
    checkOutput("irq_clear", {31'b0, irq}, 32'h0);
    ahb_write(A_CTRL, 32'h0);
    adc_mode = 0;

    for (int i = 0; i < 8; i++) applyStimulus(i);

    // Reset in the middle of a conversion.
    adc_mode = 1;
    ahb_write(A_MASK, 32'h0010);
    ahb_write(A_CTRL, 32'h1);
    wait_read_high();
    checkOutput("pre_rst_chsel", {28'h0, Channel_Select}, 32'h4);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    checkOutput("midrst_read", {31'b0, Read}, 32'h0);
    checkOutput("midrst_chsel", {28'h0, Channel_Select}, 32'h0);
    checkOutput("midrst_irq", {31'b0, irq}, 32'h0);
    checkOutput("midrst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    HRESET = 1'b0;
    adc_mode = 0;
    model_reset();
    @(posedge HCLK); #1;
    check_read("midrst_status", A_STATUS, 32'h0);
    check_read("midrst_ctrl", A_CTRL, 32'h0);
    check_read("midrst_mask", A_MASK, 32'h0);
    for (int c = 0; c < N_CH; c++) check_data(c);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
